// File: rtl/dlx_bus_responder.sv
// dlx_bus_responder: memory-side responder for the AS_N/WR_N/ACK_N strobe handshake
// Answers each captured request from a local word memory after WAIT_STATES idle cycles.
module dlx_bus_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              as_n_i,
  input  logic              wr_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              ack_n_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;
  localparam logic [3:0] LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_n_q, ack_n_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q, dout_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (!as_n_i) begin
        state_d = (WAIT_STATES == 0) ? ACK : WAIT;
        cnt_d   = '0;
      end
      WAIT: if (as_n_i) state_d = IDLE;
        else if (cnt_q == LAST) state_d = ACK;
        else cnt_d = cnt_q + 4'd1;
      ACK:     state_d = RELEASE;
      RELEASE: state_d = as_n_i ? IDLE : RELEASE;
      default: state_d = IDLE;
    endcase
  end
  // The memory access and ACK_N fall both happen on the edge that leaves ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_n_q <= 1'b1;
      dout_q  <= '0;
      wr_n_q  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_n_q <= state_q != ACK;
      if (state_q == IDLE && !as_n_i) begin
        wr_n_q <= wr_n_i;
        addr_q <= addr_i;
        din_q  <= din_i;
      end
      if (state_q == ACK && wr_n_q) dout_q <= mem[addr_q];
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == ACK && !wr_n_q) mem[addr_q] <= din_q;
  end
  assign dout_o  = dout_q;
  assign ack_n_o = ack_n_q;
  assign busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_dlx_bus_responder.sv
// tb_dlx_bus_responder: directed checks of the responder with 2 and 0 wait states
module tb_dlx_bus_responder;
  logic clk = 0, rst_n = 0;
  logic as2 = 1, wr2 = 1, ack2, busy2;
  logic [9:0] ad2 = 0;
  logic [31:0] di2 = 0, do2;
  logic as0 = 1, wr0 = 1, ack0, busy0;
  logic [9:0] ad0 = 0;
  logic [31:0] di0 = 0, do0;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  dlx_bus_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .as_n_i(as2), .wr_n_i(wr2), .addr_i(ad2), .din_i(di2),
    .dout_o(do2), .ack_n_o(ack2), .busy_o(busy2));
  dlx_bus_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .as_n_i(as0), .wr_n_i(wr0), .addr_i(ad0), .din_i(di0),
    .dout_o(do0), .ack_n_o(ack0), .busy_o(busy0));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Full request on the 2-wait instance; index i is the edge k+i
  task automatic acc2(input logic w, input logic [9:0] a, input logic [31:0] d,
                      output int first, output int pulses, output logic [31:0] rd);
    first = -1; pulses = 0;
    as2 = 0; wr2 = w; ad2 = a; di2 = d;
    for (int i = 0; i < 6; i++) begin
      step();
      if (!ack2) begin pulses++; if (first < 0) first = i; end
      if (i == 0) begin ad2 = ~a; di2 = ~d; wr2 = ~w; end
    end
    rd = do2; as2 = 1;
    step(); step();
  endtask
  task automatic acc0(input logic w, input logic [9:0] a, input logic [31:0] d,
                      output int first, output int pulses, output logic [31:0] rd);
    first = -1; pulses = 0;
    as0 = 0; wr0 = w; ad0 = a; di0 = d;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!ack0) begin pulses++; if (first < 0) first = i; end
    end
    rd = do0; as0 = 1;
    step(); step();
  endtask
  task automatic test_reset();
    repeat (2) step();
    ncmp++; if (ack2 !== 1'b1) begin nerr++; $display("FAIL reset_ack got %b want 1", ack2); end
    ncmp++; if (busy2 !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy2); end
    ncmp++; if (do2 !== 32'h0) begin nerr++; $display("FAIL reset_dout got %h want 0", do2); end
    #2 rst_n = 1;
    step();
  endtask
  task automatic test_write_read();
    int f, p; logic [31:0] rd;
    acc2(1'b0, 10'h004, 32'hDEADBEEF, f, p, rd);
    ncmp++; if (f !== 3) begin nerr++; $display("FAIL wr_latency got %0d want 3", f); end
    ncmp++; if (p !== 1) begin nerr++; $display("FAIL wr_pulses got %0d want 1", p); end
    ncmp++; if (rd !== 32'h0) begin nerr++; $display("FAIL wr_dout_unchanged got %h want 0", rd); end
    acc2(1'b1, 10'h004, 32'h0, f, p, rd);
    ncmp++; if (f !== 3) begin nerr++; $display("FAIL rd_latency got %0d want 3", f); end
    ncmp++; if (rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_data got %h want deadbeef", rd); end
    acc2(1'b0, 10'h008, 32'h01020304, f, p, rd);
    ncmp++; if (rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL dout_hold got %h want deadbeef", rd); end
  endtask
  task automatic test_top_addr();
    int f, p; logic [31:0] rd;
    acc2(1'b0, 10'h3FF, 32'h12345678, f, p, rd);
    acc2(1'b1, 10'h3FF, 32'h0, f, p, rd);
    ncmp++; if (rd !== 32'h12345678) begin nerr++; $display("FAIL top_addr got %h want 12345678", rd); end
    ncmp++; if (p !== 1) begin nerr++; $display("FAIL top_pulses got %0d want 1", p); end
  endtask
  task automatic test_abort();
    int f, p, n; logic [31:0] rd;
    for (int hold = 1; hold <= 2; hold++) begin
      n = 0;
      as2 = 0; wr2 = 0; ad2 = 10'h004; di2 = 32'hCAFEF00D;
      for (int i = 0; i < 6; i++) begin
        step();
        if (i == hold - 1) as2 = 1;
        if (!ack2) n++;
      end
      ncmp++; if (n !== 0) begin nerr++; $display("FAIL abort%0d_ack got %0d pulses want 0", hold, n); end
      ncmp++; if (busy2 !== 1'b0) begin nerr++; $display("FAIL abort%0d_busy got %b want 0", hold, busy2); end
      acc2(1'b1, 10'h004, 32'h0, f, p, rd);
      ncmp++; if (rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL abort%0d_mem got %h want deadbeef", hold, rd); end
    end
  endtask
  task automatic test_reset_mid_wait();
    int f, p; logic [31:0] rd;
    as2 = 0; wr2 = 0; ad2 = 10'h3FF; di2 = 32'hAAAA5555;
    step(); step();
    rst_n = 0;
    #1;
    ncmp++; if (ack2 !== 1'b1) begin nerr++; $display("FAIL rst_wait_ack got %b want 1", ack2); end
    ncmp++; if (busy2 !== 1'b0) begin nerr++; $display("FAIL rst_wait_busy got %b want 0", busy2); end
    ncmp++; if (do2 !== 32'h0) begin nerr++; $display("FAIL rst_wait_dout got %h want 0", do2); end
    as2 = 1;
    step();
    rst_n = 1;
    step();
    acc2(1'b1, 10'h3FF, 32'h0, f, p, rd);
    ncmp++; if (rd !== 32'h12345678) begin nerr++; $display("FAIL rst_no_write got %h want 12345678", rd); end
  endtask
  task automatic test_hold();
    int n = 0;
    as2 = 0; wr2 = 1; ad2 = 10'h004;
    for (int i = 0; i < 9; i++) begin
      step();
      if (!ack2) n++;
    end
    ncmp++; if (n !== 1) begin nerr++; $display("FAIL hold_pulses got %0d want 1", n); end
    ncmp++; if (busy2 !== 1'b1) begin nerr++; $display("FAIL hold_busy got %b want 1", busy2); end
    as2 = 1;
    step();
    ncmp++; if (busy2 !== 1'b0) begin nerr++; $display("FAIL hold_release got %b want 0", busy2); end
  endtask
  task automatic test_back_to_back();
    int f, p; logic [31:0] rd;
    logic pat [7] = '{0, 0, 1, 0, 0, 1, 1};
    logic [7:0] ackv = '1;
    acc0(1'b0, 10'h005, 32'h55AA55AA, f, p, rd);
    acc0(1'b0, 10'h006, 32'h00000066, f, p, rd);
    acc0(1'b1, 10'h005, 32'h0, f, p, rd);
    ncmp++; if (f !== 1) begin nerr++; $display("FAIL ws0_latency got %0d want 1", f); end
    ncmp++; if (rd !== 32'h55AA55AA) begin nerr++; $display("FAIL ws0_read got %h want 55aa55aa", rd); end
    wr0 = 1; ad0 = 10'h005;
    for (int i = 0; i < 7; i++) begin
      as0 = pat[i];
      if (i == 3) ad0 = 10'h006;
      step();
      if (i == 0 || i == 3) ad0 = 10'h3FF;
      ackv[i] = ack0;
      if (i == 1 && do0 !== 32'h55AA55AA) begin nerr++; $display("FAIL b2b_first got %h want 55aa55aa", do0); end
    end
    ncmp++;
    ncmp++; if (ackv !== 8'b11101101) begin nerr++; $display("FAIL b2b_acks got %b want 11101101", ackv); end
    ncmp++; if (do0 !== 32'h00000066) begin nerr++; $display("FAIL b2b_second got %h want 00000066", do0); end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_top_addr();
    test_abort();
    test_reset_mid_wait();
    test_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
